// File: rtl/dff_share_arb.sv
// Round-robin arbiter sharing one DW-bit q/q_bar register among four requesters; `PRESCALE_EN` slows sequencing to one tick per 2^PRESCALE_BITS cycles.
// Latency: grant one tick after req, write/ack on the following tick (two ticks per write).
// Backpressure: a requester holds req and wdata while gnt is high; dropping req during grant aborts without writing.
module dff_share_arb #(
    parameter int DW            = 8,
    parameter int PRESCALE_BITS = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] wdata,
    output logic [3:0]      gnt,
    output logic [1:0]      owner,
    output logic            busy,
    output logic            ack,
    output logic [DW-1:0]   q,
    output logic [DW-1:0]   q_bar,
    output logic [7:0]      wr_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       tick;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic       do_grant;
    logic       do_release;
    logic       do_write;

`ifdef PRESCALE_EN
    logic [PRESCALE_BITS-1:0] pre_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_cnt <= '0;
        else      pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = &pre_cnt;
`else
    assign tick = 1'b1;
`endif

    // Search downward so the set bit nearest ptr is assigned last and wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) winner = ptr + 2'(k);
        end
    end

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_release = 1'b0;
        do_write   = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        do_grant  = 1'b1;
                        state_nxt = GRANT;
                    end
                end
                GRANT: begin
                    do_release = 1'b1;
                    do_write   = req[owner];
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            q        <= '0;
            wr_count <= '0;
            ptr      <= '0;
        end else begin
            ack <= do_write;
            if (do_grant) begin
                gnt   <= 4'b0001 << winner;
                owner <= winner;
                busy  <= 1'b1;
            end else if (do_release) begin
                gnt  <= '0;
                busy <= 1'b0;
            end
            if (do_write) begin
                q        <= wdata[owner*DW +: DW];
                wr_count <= wr_count + 8'd1;
                ptr      <= owner + 2'd1;
            end
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_dff_share_arb.sv
// Self-checking bench for dff_share_arb (default build, tick every cycle): directed scenarios plus randomized traffic against a behavioural model.
module tb_dff_share_arb;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      req = 4'h0;
    logic [4*DW-1:0] wdata = '0;
    logic [3:0]      gnt;
    logic [1:0]      owner;
    logic            busy;
    logic            ack;
    logic [DW-1:0]   q;
    logic [DW-1:0]   q_bar;
    logic [7:0]      wr_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Behavioural model of the arbiter's observable state.
    bit         m_busy;
    bit         m_ack;
    int         m_owner;
    int         m_ptr;
    int         m_cnt;
    logic [7:0] m_q;
    logic [3:0] m_gnt;

    dff_share_arb #(.DW(DW), .PRESCALE_BITS(17)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .owner(owner), .busy(busy), .ack(ack),
        .q(q), .q_bar(q_bar), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_ack = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_q = 8'h00; m_gnt = 4'h0;
    endtask

    // Advance one clock edge, update the model from the inputs seen at that edge, settle 1ns.
    task automatic step();
        int w;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            m_ack = 0;
            if (!m_busy) begin
                if (req != 4'h0) begin
                    w = m_ptr;
                    while (!req[w]) w = (w + 1) % 4;
                    m_busy = 1; m_owner = w; m_gnt = 4'(1 << w);
                end
            end else begin
                if (req[m_owner]) begin
                    m_q   = wdata[m_owner*8 +: 8];
                    m_cnt = (m_cnt + 1) % 256;
                    m_ptr = (m_owner + 1) % 4;
                    m_ack = 1;
                end
                m_busy = 0; m_gnt = 4'h0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req = 4'h0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'hF; wdata = {$urandom, $urandom} ;
        #2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++;
            if ({q, q_bar, gnt, ack, busy, owner, wr_count} !== {8'h00, 8'hFF, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0})
                $display("FAIL reset cyc%0d: q=%h q_bar=%h gnt=%b ack=%b busy=%b owner=%0d wr_count=%0d, want 00 ff 0000 0 0 0 0",
                         i, q, q_bar, gnt, ack, busy, owner, wr_count);
            else pass_cnt++;
        end
        rst = 1'b1; req = 4'h0;
    endtask

    task automatic test_single();
        req = 4'b0100; wdata = {8'h3C, 8'hA5, 8'h77, 8'h01};
        step();
        chk_cnt++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || ack !== 1'b0 || owner !== 2'd2)
            $display("FAIL single_grant: gnt=%b busy=%b ack=%b owner=%0d, want 0100 1 0 2", gnt, busy, ack, owner);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (q !== 8'hA5 || q_bar !== 8'h5A || ack !== 1'b1 || wr_count !== 8'd1 || gnt !== 4'h0)
            $display("FAIL single_write: q=%h q_bar=%h ack=%b wr_count=%0d gnt=%b, want a5 5a 1 1 0000",
                     q, q_bar, ack, wr_count, gnt);
        else pass_cnt++;
        req = 4'h0;
        step();
        chk_cnt++;
        if (ack !== 1'b0 || busy !== 1'b0 || q !== 8'hA5)
            $display("FAIL single_ack_pulse: ack=%b busy=%b q=%h, want 0 0 a5", ack, busy, q);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_q [5];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        apply_reset();
        req = 4'hF; wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            step();
            chk_cnt++;
            if (gnt !== 4'(1 << (i % 4)) || ack !== 1'b0)
                $display("FAIL rr_grant%0d: gnt=%b ack=%b, want %b 0", i, gnt, ack, 4'(1 << (i % 4)));
            else pass_cnt++;
            step();
            chk_cnt++;
            if (q !== exp_q[i] || ack !== 1'b1 || wr_count !== 8'(i + 1))
                $display("FAIL rr_write%0d: q=%h ack=%b wr_count=%0d, want %h 1 %0d", i, q, ack, wr_count, exp_q[i], i + 1);
            else pass_cnt++;
        end
        req = 4'h0;
        step();
    endtask

    task automatic test_abort();
        logic [7:0] q0;
        logic [7:0] c0;
        q0 = q; c0 = wr_count;
        req = 4'b0001; wdata = {24'h0, ~q0};
        step();
        chk_cnt++;
        if (gnt !== 4'b0001 || busy !== 1'b1)
            $display("FAIL abort_grant: gnt=%b busy=%b, want 0001 1", gnt, busy);
        else pass_cnt++;
        req = 4'h0;
        step();
        chk_cnt++;
        if (ack !== 1'b0 || q !== q0 || wr_count !== c0 || gnt !== 4'h0 || busy !== 1'b0)
            $display("FAIL abort_release: ack=%b q=%h wr_count=%0d gnt=%b busy=%b, want 0 %h %0d 0000 0",
                     ack, q, wr_count, gnt, busy, q0, c0);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (gnt !== 4'h0 || busy !== 1'b0 || ack !== 1'b0)
            $display("FAIL abort_idle: gnt=%b busy=%b ack=%b, want 0000 0 0", gnt, busy, ack);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_grant();
        // Complete a write by requester 1 so the pointer moves past 0 before reset.
        req = 4'b0010; wdata = {8'h00, 8'h00, 8'h5E, 8'h00};
        step(); step();
        req = 4'b0100;
        step();
        chk_cnt++;
        if (busy !== 1'b1 || gnt !== 4'b0100)
            $display("FAIL midrst_grant: busy=%b gnt=%b, want 1 0100", busy, gnt);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        model_reset();
        chk_cnt++;
        if ({q, q_bar, gnt, ack, busy, owner, wr_count} !== {8'h00, 8'hFF, 4'h0, 1'b0, 1'b0, 2'd0, 8'd0})
            $display("FAIL midrst_async: q=%h q_bar=%h gnt=%b ack=%b busy=%b owner=%0d wr_count=%0d, want 00 ff 0000 0 0 0 0",
                     q, q_bar, gnt, ack, busy, owner, wr_count);
        else pass_cnt++;
        step();
        rst = 1'b1; req = 4'b1010;
        step();
        chk_cnt++;
        if (gnt !== 4'b0010 || owner !== 2'd1)
            $display("FAIL midrst_ptr: gnt=%b owner=%0d, want 0010 1", gnt, owner);
        else pass_cnt++;
        step();
        req = 4'h0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] act;
        logic [31:0] exp;
        int errs = 0;
        for (int i = 0; i < 300; i++) begin
            req   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            wdata = $urandom;
            step();
            act = {gnt, owner, busy, ack, q, q_bar, wr_count};
            exp = {m_gnt, 2'(m_owner), m_busy, m_ack, m_q, ~m_q, 8'(m_cnt)};
            chk_cnt++;
            if (act !== exp) begin
                if (errs < 10)
                    $display("FAIL random%0d: {gnt,owner,busy,ack,q,q_bar,cnt}=%h, want %h", i, act, exp);
                errs++;
            end else pass_cnt++;
        end
        req = 4'h0;
        step();
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 4'b0001;
        for (int i = 1; i <= 256; i++) begin
            wdata = {24'h0, 8'($urandom)};
            step(); step();
            if (i == 255) begin
                chk_cnt++;
                if (wr_count !== 8'd255 || ack !== 1'b1)
                    $display("FAIL wrap_255: wr_count=%0d ack=%b, want 255 1", wr_count, ack);
                else pass_cnt++;
            end
            if (i == 256) begin
                chk_cnt++;
                if (wr_count !== 8'd0 || ack !== 1'b1 || q !== wdata[7:0])
                    $display("FAIL wrap_0: wr_count=%0d ack=%b q=%h, want 0 1 %h", wr_count, ack, q, wdata[7:0]);
                else pass_cnt++;
            end
        end
        req = 4'h0;
        step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_reset_mid_grant();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dff_share_arb.md
# dff_share_arb

Round-robin arbiter and write sequencer that shares one DW-bit D flip-flop storage register (q/q_bar pair) among four requesters. It sits between board-level sources (switches, upstream logic) and the shared register and grants write access to one requester at a time. An optional prescaler slows the sequencing to a human-visible rate for board bring-up.

## Interface
- DW, 8, width of shared register and of each requester's data slice
- PRESCALE_BITS, 17, prescaler counter width (used only when PRESCALE_EN defined)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  4  per-requester write request, level, bit i = requester i
- wdata  in  4*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  4  one-hot grant, registered
- owner  out  2  index of current/last granted requester
- busy  out  1  high while FSM is in GRANT
- ack  out  1  one-cycle pulse on the edge q is written
- q  out  DW  shared register value
- q_bar  out  DW  bitwise inverse of q, always ~q
- wr_count  out  8  completed writes, wraps 255 -> 0

## Operation
- Reset values: q=0, q_bar=all ones, gnt=0, owner=0, busy=0, ack=0, wr_count=0, priority pointer ptr=0, prescaler=0, state=IDLE.
- tick: FSM advance enable. Without PRESCALE_EN, tick=1 every cycle. With it, see Configuration.
- FSM states IDLE, GRANT. All transitions only on edges where tick=1; ack is 0 on every non-write edge.
- IDLE: if any req bit set, select winner = first set bit searching ptr, ptr+1, ... modulo 4; gnt <= one-hot(winner), owner <= winner, busy <= 1, go GRANT. No req: stay IDLE, outputs hold.
- GRANT: if req[owner]=1: q <= wdata slice of owner, q_bar <= ~same, ack <= 1, wr_count <= wr_count+1, ptr <= owner+1 mod 4. If req[owner]=0 (abort): no write, no ack, wr_count and ptr unchanged. Either case: gnt <= 0, busy <= 0, go IDLE.
- Data sampled on the GRANT->IDLE edge, not at grant time; requester must hold wdata stable while gnt is high.
- owner holds last granted index in IDLE.
- Fairness: after requester i completes a write it has lowest priority; with all four requesting, write order 0,1,2,3,0,...
- req changes during GRANT for non-owners have no effect until next IDLE evaluation.
- Reset asserted mid-GRANT: immediate return to reset values; no partial write.

## Timing
- Without prescaler: req high before edge 1 -> gnt/busy high after edge 1 -> q, ack, wr_count update at edge 2, gnt low after edge 2. Write latency 2 cycles; max throughput one write per 2 cycles.
- With prescaler: same sequence counted in ticks; each step waits for next tick edge.
- ack high exactly one clk cycle regardless of prescaler.
- Reset release is asynchronous-assert; first arbitration on first tick edge after deassertion.

## Configuration
- PRESCALE_EN defined: free-running PRESCALE_BITS-bit counter, reset to 0, increments every cycle, wraps; tick=1 only on the cycle the counter equals all ones (one tick per 2^PRESCALE_BITS cycles, default 131072). For board demo with LED outputs.
- PRESCALE_EN undefined: no counter instantiated, tick tied to 1; used for simulation and when driven by a system clock already at the target rate.

## Test plan
- Reset: rst=0 with req=4'hF -> q=0x00, q_bar=0xFF, gnt=0, ack=0, wr_count=0; held until rst=1.
- Single requester: req=4'b0100, wdata slice 2=0xA5 -> gnt=4'b0100 after edge 1; q=0xA5, q_bar=0x5A, ack pulse, wr_count=1 at edge 2.
- Round robin: req=4'hF held, slices 0x11,0x22,0x33,0x44 -> q sequence 0x11,0x22,0x33,0x44,0x11, one write every 2 cycles.
- Abort: req=4'b0001 granted, req dropped to 0 before next edge -> no ack, q unchanged, wr_count unchanged, gnt=0, FSM IDLE.
- Reset mid-grant: rst low while busy=1 -> all outputs to reset values immediately; after rst=1, req=4'b0010 is granted first (ptr=0 search).
- Wrap: 256 completed writes -> wr_count 255 -> 0; with PRESCALE_EN and PRESCALE_BITS=3, gnt asserts only on every 8th cycle.
